// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath blocks.
//   - FSM state encoding used by spike_mac_accum
//   - clog2 helper that never returns 0, so index buses are at least 1 bit
//   - default weight/sum width
package snn_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;

   localparam logic [1:0] STATE_IDLE  = 2'd0;
   localparam logic [1:0] STATE_ACCUM = 2'd1;
   localparam logic [1:0] STATE_EMIT  = 2'd2;

   typedef enum logic [1:0] {
      StIdle  = STATE_IDLE,
      StAccum = STATE_ACCUM,
      StEmit  = STATE_EMIT
   } mac_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((32'd1 << width) < value) begin
         width++;
      end
      return (width == 0) ? 1 : width;
   endfunction

endpackage

// File: rtl/spike_weight_mem.sv
// Synaptic weight register file for spike_mac_accum.
// N_IN entries of DATA_WIDTH bits, cleared asynchronously by rst_n.
// Ports:
//   clk, rst_n         clock, asynchronous active-low clear
//   we, waddr, wdata   write port; takes effect on the next rising edge,
//                      addresses >= N_IN are dropped
//   raddr, rdata       combinational read port (returns pre-write contents
//                      when read and write hit the same entry in one cycle)
module spike_weight_mem
   import snn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned N_IN       = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [clog2(N_IN)-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [clog2(N_IN)-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);

   localparam int unsigned AddrW = clog2(N_IN);

   logic [DATA_WIDTH-1:0] mem_q [N_IN];
   logic                  waddr_ok;
   logic                  raddr_ok;

   // With a power-of-two depth every address is in range; skip the compare.
   if (N_IN == (32'd1 << AddrW)) begin : g_full_range
      assign waddr_ok = 1'b1;
      assign raddr_ok = 1'b1;
   end else begin : g_part_range
      assign waddr_ok = (32'(waddr) < N_IN);
      assign raddr_ok = (32'(raddr) < N_IN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_IN; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we && waddr_ok) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = raddr_ok ? mem_q[raddr] : '0;

endmodule

// File: rtl/spike_mac_accum.sv
// Presynaptic accumulator: sums the weights of all active inputs of one
// accepted spike vector and emits the saturated total as a one-cycle pulse
// that feeds neuron_body (in_valid / in_mac_sum).
// Build option: define SPIKE_MAC_SKIP_ZERO_EN to visit only the set bits of
// the vector (latency popcount+1) instead of the fixed N_IN-cycle scan.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_valid, s_ready, s_spikes spike vector handshake (ready only in IDLE)
//   w_we, w_addr, w_data       weight write port, accepted in any state
//   out_valid, out_mac_sum     one-cycle result pulse; sum holds until next
//   out_busy                   high while accumulating or emitting
module spike_mac_accum
   import snn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned N_IN       = 16,
   parameter int unsigned MAX_SUM    = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [N_IN-1:0]          s_spikes,
   input  logic                     w_we,
   input  logic [clog2(N_IN)-1:0]   w_addr,
   input  logic [DATA_WIDTH-1:0]    w_data,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    out_mac_sum,
   output logic                     out_busy
);

   localparam int unsigned IdxW = clog2(N_IN);
   // Wide enough for N_IN full-scale weights, so the running sum never wraps.
   localparam int unsigned AccW = DATA_WIDTH + IdxW;

   mac_state_e            state_q, state_d;
   logic [N_IN-1:0]       vec_q, vec_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [AccW-1:0]       acc_q, acc_d;
   logic [DATA_WIDTH-1:0] sum_q, sum_d;
   logic [DATA_WIDTH-1:0] weight_rd;
   logic [AccW-1:0]       acc_next;

   function automatic logic [DATA_WIDTH-1:0] saturate(input logic [AccW-1:0] acc);
      if (acc > AccW'(MAX_SUM)) begin
         return DATA_WIDTH'(MAX_SUM);
      end
      return acc[DATA_WIDTH-1:0];
   endfunction

   // Priority encoder: index of the lowest set bit (0 for an empty vector).
   function automatic logic [IdxW-1:0] lowest_set(input logic [N_IN-1:0] vec);
      logic [IdxW-1:0] idx;
      idx = '0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IdxW'(i);
         end
      end
      return idx;
   endfunction

   spike_weight_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .N_IN       (N_IN)
   ) u_weight_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (w_we),
      .waddr (w_addr),
      .wdata (w_data),
      .raddr (idx_q),
      .rdata (weight_rd)
   );

   assign acc_next = vec_q[idx_q] ? (acc_q + AccW'(weight_rd)) : acc_q;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      unique case (state_q)
         StIdle: begin
            if (s_valid) begin
               vec_d   = s_spikes;
               acc_d   = '0;
               idx_d   = '0;
               state_d = StAccum;
`ifdef SPIKE_MAC_SKIP_ZERO_EN
               idx_d = lowest_set(s_spikes);
               if (s_spikes == '0) begin
                  state_d = StEmit;
                  sum_d   = '0;
               end
`endif
            end
         end
         StAccum: begin
            acc_d = acc_next;
`ifdef SPIKE_MAC_SKIP_ZERO_EN
            // Retire the visited bit; the remaining set bits drive the scan.
            vec_d[idx_q] = 1'b0;
            if (vec_d == '0) begin
               state_d = StEmit;
               sum_d   = saturate(acc_next);
            end else begin
               idx_d = lowest_set(vec_d);
            end
`else
            if (idx_q == IdxW'(N_IN - 1)) begin
               state_d = StEmit;
               sum_d   = saturate(acc_next);
            end else begin
               idx_d = idx_q + 1'b1;
            end
`endif
         end
         StEmit: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         vec_q   <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
      end
   end

   // All outputs decode flops only.
   assign s_ready     = (state_q == StIdle);
   assign out_valid   = (state_q == StEmit);
   assign out_busy    = (state_q == StAccum) || (state_q == StEmit);
   assign out_mac_sum = sum_q;

endmodule

// File: tb/tb_spike_mac_accum.sv
// Scoreboard bench for spike_mac_accum. Two instances share all inputs:
// dut_a uses the default ceiling (255), dut_b uses MAX_SUM=100. The driver
// pushes the hand-computed raw sum and the expected pulse cycle on every
// accepted vector; per-instance monitors pop and compare on each out_valid.
module tb_spike_mac_accum;

   typedef struct {
      int sum;
      int cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        s_valid;
   logic [15:0] s_spikes;
   logic        w_we;
   logic [3:0]  w_addr;
   logic [7:0]  w_data;

   logic        s_ready_a, out_valid_a, out_busy_a;
   logic [7:0]  out_mac_sum_a;
   logic        s_ready_b, out_valid_b, out_busy_b;
   logic [7:0]  out_mac_sum_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   exp_t qa[$];
   exp_t qb[$];

   spike_mac_accum #(
      .DATA_WIDTH (8),
      .N_IN       (16),
      .MAX_SUM    (255)
   ) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready_a),
      .s_spikes    (s_spikes),
      .w_we        (w_we),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .out_valid   (out_valid_a),
      .out_mac_sum (out_mac_sum_a),
      .out_busy    (out_busy_a)
   );

   spike_mac_accum #(
      .DATA_WIDTH (8),
      .N_IN       (16),
      .MAX_SUM    (100)
   ) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready_b),
      .s_spikes    (s_spikes),
      .w_we        (w_we),
      .w_addr      (w_addr),
      .w_data      (w_data),
      .out_valid   (out_valid_b),
      .out_mac_sum (out_mac_sum_b),
      .out_busy    (out_busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Handshake-to-pulse latency in cycles for a 16-input vector.
   function automatic int lat_of(input logic [15:0] vec);
`ifdef SPIKE_MAC_SKIP_ZERO_EN
      return $countones(vec) + 1;
`else
      if (vec == 16'h0) return 17;
      return 17;
`endif
   endfunction

   function automatic int min_of(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Monitors: every pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (out_valid_a) begin
         if (qa.size() == 0) begin
            check("unexpected_pulse_a", 1, 0);
         end else begin
            exp_t e;
            e = qa.pop_front();
            check("sum_a", int'(out_mac_sum_a), min_of(e.sum, 255));
            check("pulse_cycle_a", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (out_valid_b) begin
         if (qb.size() == 0) begin
            check("unexpected_pulse_b", 1, 0);
         end else begin
            exp_t e;
            e = qb.pop_front();
            check("sum_b", int'(out_mac_sum_b), min_of(e.sum, 100));
            check("pulse_cycle_b", cyc, e.cyc);
         end
      end
   end

   task automatic write_w(input int addr, input int data);
      w_we   = 1'b1;
      w_addr = 4'(addr);
      w_data = 8'(data);
      @(posedge clk);
      #1;
      w_we   = 1'b0;
   endtask

   // Presents vec with s_valid high until accepted; returns the handshake
   // cycle. Leaves s_valid high and returns 1 time unit after the accepting
   // edge (i.e. in T1).
   task automatic accept(input logic [15:0] vec, input int raw, input bit push,
                         output int t0);
      bit   got;
      exp_t e;
      got      = 1'b0;
      s_valid  = 1'b1;
      s_spikes = vec;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (s_ready_a) got = 1'b1;
      end
      t0 = cyc;
      if (!got) begin
         check("handshake_timeout", 0, 1);
      end else if (push) begin
         e.sum = raw;
         e.cyc = t0 + lat_of(vec);
         qa.push_back(e);
         qb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 300; k++) begin
         if (qa.size() == 0 && qb.size() == 0 && s_ready_a) break;
         @(negedge clk);
      end
      check("drain_outstanding", qa.size() + qb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t0;
      int t0b;
      int hits;
      int k;

      rst_n    = 1'b0;
      s_valid  = 1'b0;
      s_spikes = 16'h0;
      w_we     = 1'b0;
      w_addr   = 4'h0;
      w_data   = 8'h0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      check("reset_s_ready", int'(s_ready_a), 1);
      check("reset_out_valid", int'(out_valid_a), 0);
      check("reset_out_mac_sum", int'(out_mac_sum_a), 0);
      check("reset_out_busy", int'(out_busy_a), 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) write_w(i, i + 1);

      // Basic sum: w0 + w2 = 1 + 3, ready low for the whole busy window.
      accept(16'h0005, 4, 1'b1, t0);
      s_valid = 1'b0;
      hits = 0;
      for (int i = 0; i < lat_of(16'h0005); i++) begin
         @(negedge clk);
         if (s_ready_a) hits++;
      end
      check("ready_low_window", hits, 0);
      @(negedge clk);
      check("ready_after_emit", int'(s_ready_a), 1);
      @(posedge clk);
      #1;

      // All-zero vector still emits 0.
      accept(16'h0000, 0, 1'b1, t0);
      s_valid = 1'b0;

      // Back-to-back with s_valid held; s_spikes wiggled mid-ACCUM.
      accept(16'h0001, 1, 1'b1, t0);
      s_spikes = 16'hFFFF;
      @(posedge clk);
      #1;
      accept(16'h0003, 3, 1'b1, t0b);
      s_valid = 1'b0;
      check("b2b_accept_cycle", t0b, t0 + lat_of(16'h0001) + 1);

      // Full vector: 1+2+...+16 = 136, clipped to 100 on dut_b.
      accept(16'hFFFF, 136, 1'b1, t0);
      s_valid = 1'b0;

      // Write collision on w[3]: the scan sees the old value, next vector the new.
      wait_drain();
      write_w(3, 10);
      accept(16'h0008, 10, 1'b1, t0);
      s_valid = 1'b0;
`ifdef SPIKE_MAC_SKIP_ZERO_EN
      k = 1;
`else
      k = 4;
`endif
      for (int i = 1; i < k; i++) begin
         @(posedge clk);
         #1;
      end
      write_w(3, 50);
      accept(16'h0008, 50, 1'b1, t0);
      s_valid = 1'b0;

      // Saturation: 16 x 200 = 3200.
      wait_drain();
      for (int i = 0; i < 16; i++) write_w(i, 200);
      accept(16'hFFFF, 3200, 1'b1, t0);
      s_valid = 1'b0;

      // Two-input skip case: w0 + w15 = 1 + 16.
      wait_drain();
      for (int i = 0; i < 16; i++) write_w(i, i + 1);
      accept(16'h8001, 17, 1'b1, t0);
      s_valid = 1'b0;

      // Reset mid-ACCUM: vector discarded, no pulse, weights cleared.
      wait_drain();
      accept(16'hFFFF, 0, 1'b0, t0);
      s_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midreset_out_valid", int'(out_valid_a), 0);
      check("midreset_out_mac_sum", int'(out_mac_sum_a), 0);
      check("midreset_out_busy", int'(out_busy_a), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("postreset_s_ready", int'(s_ready_a), 1);
      check("postreset_out_valid", int'(out_valid_a), 0);
      @(posedge clk);
      #1;
      accept(16'hFFFF, 0, 1'b1, t0);
      s_valid = 1'b0;

      wait_drain();
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
